// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } ps2_state_e;

    // Bit positions inside the first (status) byte of a packet
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XSIGN = 4;
    localparam int YSIGN = 5;
    localparam int XOVF  = 6;
    localparam int YOVF  = 7;

    // Default screen geometry and timeout
    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_POS_W       = 10;
    localparam int DEF_TIMEOUT_CYC = 200000;

    // Only the status fields the update actually consumes are kept
    typedef struct packed {
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sign;
        logic       x_sign;
        logic [2:0] btn;     // {Middle, Right, Left}
    } ps2_status_t;

endpackage

// File: rtl/mouse_axis_clamp.sv
// One axis of cursor motion: applies a signed 9-bit delta to the current
// position and clamps the result to 0..max_pos. Purely combinational.
module mouse_axis_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int POS_W = DEF_POS_W
) (
    input  logic [POS_W-1:0]  pos,
    input  logic signed [8:0] delta,
    input  logic              ovf,      // overflowed axis contributes no motion
    input  logic              invert,   // subtract the delta (PS/2 +Y is up, screen Y is down)
    input  logic [POS_W-1:0]  max_pos,
    output logic [POS_W-1:0]  next_pos
);

    localparam int SW = POS_W + 2;

    logic signed [SW-1:0] pos_s;
    logic signed [SW-1:0] delta_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] max_s;

    // Widen to a signed range that cannot overflow, then saturate at both ends
    always_comb begin
        pos_s   = signed'({2'b00, pos});
        max_s   = signed'({2'b00, max_pos});
        delta_s = ovf ? '0 : signed'({{(SW-9){delta[8]}}, delta});
        sum_s   = invert ? (pos_s - delta_s) : (pos_s + delta_s);
        if (sum_s < 0) begin
            next_pos = '0;
        end else if (sum_s > max_s) begin
            next_pos = max_pos;
        end else begin
            next_pos = sum_s[POS_W-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte packets from byte strobes,
// decodes buttons and keeps a clamped cursor position.
// Optional inter-byte timeout enabled by defining PS2_MOUSE_TIMEOUT_EN.
//
// state   | meaning
// WAIT_B0 | expecting status byte (bit 3 must be set)
// WAIT_B1 | status latched, expecting X byte
// WAIT_B2 | X latched, expecting Y byte
// UPDATE  | one cycle: apply motion/buttons; a byte arriving now is a new status byte
module ps2_mouse_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int POS_W       = DEF_POS_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             CLK,
    input  logic             Resetn,
    input  logic [7:0]       RxByte,
    input  logic             RxValid,
    input  logic             Recenter,
    output logic [POS_W-1:0] PosX,
    output logic [POS_W-1:0] PosY,
    output logic [2:0]       Buttons,
    output logic             PacketValid,
    output logic [7:0]       SyncErrCnt
);

    localparam logic [POS_W-1:0] CTR_X = POS_W'(SCREEN_W / 2);
    localparam logic [POS_W-1:0] CTR_Y = POS_W'(SCREEN_H / 2);
    localparam logic [POS_W-1:0] MAX_X = POS_W'(SCREEN_W - 1);
    localparam logic [POS_W-1:0] MAX_Y = POS_W'(SCREEN_H - 1);

    ps2_state_e       state_q, state_d, eff_state;
    ps2_status_t      status_q, status_d;
    logic [7:0]       xbyte_q, xbyte_d;
    logic [7:0]       ybyte_q, ybyte_d;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic [2:0]       buttons_q, buttons_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [7:0]       sync_err_q, sync_err_d;

    logic             timeout_hit;
    logic signed [8:0] dx, dy;
    logic [POS_W-1:0] next_x, next_y;

    assign dx = {status_q.x_sign, xbyte_q};
    assign dy = {status_q.y_sign, ybyte_q};

    mouse_axis_clamp #(.POS_W(POS_W)) u_clamp_x (
        .pos      (pos_x_q),
        .delta    (dx),
        .ovf      (status_q.x_ovf),
        .invert   (1'b0),
        .max_pos  (MAX_X),
        .next_pos (next_x)
    );

    mouse_axis_clamp #(.POS_W(POS_W)) u_clamp_y (
        .pos      (pos_y_q),
        .delta    (dy),
        .ovf      (status_q.y_ovf),
        .invert   (1'b1),
        .max_pos  (MAX_Y),
        .next_pos (next_y)
    );

`ifdef PS2_MOUSE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          mid_packet;

    assign mid_packet  = (state_q == WAIT_B1) || (state_q == WAIT_B2);
    assign timeout_hit = mid_packet && (tmo_cnt_q == TW'(TIMEOUT_CYC));

    // Inter-byte timer: restarts on every byte, runs only between bytes of a packet
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (RxValid || !mid_packet) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TW'(TIMEOUT_CYC)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Timer register
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, byte capture, packet update and recentre
    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        xbyte_d     = xbyte_q;
        ybyte_d     = ybyte_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        buttons_d   = buttons_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = sync_err_q;
        eff_state   = state_q;

        // A timed-out partial packet is dropped; a coincident byte restarts framing
        if (timeout_hit) begin
            eff_state = WAIT_B0;
            state_d   = WAIT_B0;
        end

        if (state_q == UPDATE) begin
            buttons_d   = status_q.btn;
            pos_x_d     = next_x;
            pos_y_d     = next_y;
            pkt_valid_d = 1'b1;
            state_d     = WAIT_B0;
        end

        if (RxValid) begin
            case (eff_state)
                WAIT_B0, UPDATE: begin
                    if (RxByte[SYNC]) begin
                        status_d.btn    = {RxByte[BTN_M], RxByte[BTN_R], RxByte[BTN_L]};
                        status_d.x_sign = RxByte[XSIGN];
                        status_d.y_sign = RxByte[YSIGN];
                        status_d.x_ovf  = RxByte[XOVF];
                        status_d.y_ovf  = RxByte[YOVF];
                        state_d         = WAIT_B1;
                    end else if (sync_err_q != 8'hFF) begin
                        sync_err_d = sync_err_q + 8'd1;
                    end
                end
                WAIT_B1: begin
                    xbyte_d = RxByte;
                    state_d = WAIT_B2;
                end
                WAIT_B2: begin
                    ybyte_d = RxByte;
                    state_d = UPDATE;
                end
                default: state_d = WAIT_B0;
            endcase
        end

        // Recentre overrides any motion applied in the same cycle
        if (Recenter) begin
            pos_x_d = CTR_X;
            pos_y_d = CTR_Y;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= WAIT_B0;
            status_q    <= '0;
            xbyte_q     <= '0;
            ybyte_q     <= '0;
            pos_x_q     <= CTR_X;
            pos_y_q     <= CTR_Y;
            buttons_q   <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            xbyte_q     <= xbyte_d;
            ybyte_q     <= ybyte_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            buttons_q   <= buttons_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign PosX        = pos_x_q;
    assign PosY        = pos_y_q;
    assign Buttons     = buttons_q;
    assign PacketValid = pkt_valid_q;
    assign SyncErrCnt  = sync_err_q;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Scoreboard bench for ps2_mouse_decoder: stimulus pushes hand-computed
// expected updates, a negedge monitor pops and compares on PacketValid.
module tb_ps2_mouse_decoder;

    localparam int  TB_TMO = 50;
    localparam time PER    = 10;

    logic       CLK = 1'b0;
    logic       Resetn;
    logic [7:0] RxByte;
    logic       RxValid;
    logic       Recenter;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic [2:0] Buttons;
    logic       PacketValid;
    logic [7:0] SyncErrCnt;

    ps2_mouse_decoder #(.TIMEOUT_CYC(TB_TMO)) dut (
        .CLK         (CLK),
        .Resetn      (Resetn),
        .RxByte      (RxByte),
        .RxValid     (RxValid),
        .Recenter    (Recenter),
        .PosX        (PosX),
        .PosY        (PosY),
        .Buttons     (Buttons),
        .PacketValid (PacketValid),
        .SyncErrCnt  (SyncErrCnt)
    );

    always #(PER/2) CLK = ~CLK;

    typedef struct {
        int     x;
        int     y;
        int     b;
        longint t;
    } exp_s;

    exp_s sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pv_prev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every PacketValid must match the oldest expectation, value and time
    always @(negedge CLK) begin
        if (PacketValid) begin
            chk("pv_width", longint'(pv_prev), 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pv: got pos %0d,%0d btn %0d expected no update", PosX, PosY, Buttons);
            end else begin
                exp_s e;
                e = sb.pop_front();
                chk("pos_x", longint'(PosX), e.x);
                chk("pos_y", longint'(PosY), e.y);
                chk("buttons", longint'(Buttons), e.b);
                chk("latency", longint'($time), e.t);
            end
        end
        pv_prev = PacketValid;
    end

    task automatic send_byte(input logic [7:0] b, output longint t);
        @(negedge CLK);
        RxByte  = b;
        RxValid = 1'b1;
        t       = longint'($time);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int ex, input int ey, input int eb);
        longint t;
        exp_s   e;
        send_byte(b0, t);
        send_byte(b1, t);
        send_byte(b2, t);
        e.x = ex; e.y = ey; e.b = eb; e.t = t + 2*PER;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RxValid = 1'b0;
        end
    endtask

    task automatic recenter_chk();
        @(negedge CLK);
        RxValid  = 1'b0;
        Recenter = 1'b1;
        @(negedge CLK);
        Recenter = 1'b0;
        chk("recenter_x", longint'(PosX), 320);
        chk("recenter_y", longint'(PosY), 240);
    endtask

    initial begin
        longint t;
        exp_s   e;
        Resetn   = 1'b0;
        RxByte   = 8'h00;
        RxValid  = 1'b0;
        Recenter = 1'b0;
        repeat (3) @(negedge CLK);
        Resetn = 1'b1;
        @(negedge CLK);
        chk("rst_x", longint'(PosX), 320);
        chk("rst_y", longint'(PosY), 240);
        chk("rst_btn", longint'(Buttons), 0);
        chk("rst_pv", longint'(PacketValid), 0);
        chk("rst_err", longint'(SyncErrCnt), 0);

        // Reset in the middle of a packet discards the partial bytes
        send_byte(8'h08, t);
        send_byte(8'h05, t);
        @(negedge CLK);
        RxValid = 1'b0;
        Resetn  = 1'b0;
        repeat (2) @(negedge CLK);
        Resetn = 1'b1;
        @(negedge CLK);
        chk("midrst_x", longint'(PosX), 320);
        chk("midrst_y", longint'(PosY), 240);
        chk("midrst_btn", longint'(Buttons), 0);
        chk("midrst_err", longint'(SyncErrCnt), 0);
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);
        idle(3);

        // Basic packet with left button
        recenter_chk();
        send_pkt(8'h09, 8'h05, 8'h03, 325, 237, 1);
        idle(3);

        // Negative X motion, then clamp at left edge
        recenter_chk();
        send_pkt(8'h18, 8'hF6, 8'h00, 310, 240, 0);
        idle(3);
        recenter_chk();
        send_pkt(8'h18, 8'h01, 8'h00, 65, 240, 0);
        send_pkt(8'h08, 8'h0A, 8'h00, 75, 240, 0);
        send_pkt(8'h18, 8'hBA, 8'h00, 5, 240, 0);
        idle(3);
        send_pkt(8'h18, 8'hF6, 8'h00, 0, 240, 0);
        idle(3);

        // Downward motion and clamp at bottom edge
        send_pkt(8'h28, 8'h00, 8'h60, 0, 400, 0);
        send_pkt(8'h28, 8'h00, 8'h80, 0, 479, 0);
        idle(3);

        // Resync on a stray byte
        send_byte(8'h00, t);
        idle(2);
        chk("resync_err", longint'(SyncErrCnt), 1);
        send_pkt(8'h0A, 8'h00, 8'h00, 0, 479, 2);
        idle(3);

        // X overflow, then a packet whose first byte lands in the UPDATE cycle
        recenter_chk();
        send_pkt(8'h48, 8'h7F, 8'h02, 320, 238, 0);
        send_pkt(8'h09, 8'h05, 8'h03, 325, 235, 1);
        idle(3);
        chk("b2b_err", longint'(SyncErrCnt), 1);

        // Recenter coinciding with UPDATE: position centred, buttons still update
        send_pkt(8'h0C, 8'h10, 8'h10, 320, 240, 4);
        @(negedge CLK);
        RxValid  = 1'b0;
        Recenter = 1'b1;
        @(negedge CLK);
        Recenter = 1'b0;
        idle(3);

        // Partial packet followed by a long idle gap
        send_byte(8'h08, t);
        send_byte(8'h05, t);
        idle(TB_TMO + 1);
`ifdef PS2_MOUSE_TIMEOUT_EN
        send_pkt(8'h08, 8'h01, 8'h01, 321, 239, 0);
        idle(3);
        chk("tmo_err", longint'(SyncErrCnt), 1);
`else
        send_byte(8'h08, t);
        e.x = 325; e.y = 232; e.b = 0; e.t = t + 2*PER;
        sb.push_back(e);
        send_byte(8'h01, t);
        send_byte(8'h01, t);
        idle(3);
        chk("tmo_err", longint'(SyncErrCnt), 3);
`endif

        // Error counter saturates
        repeat (260) send_byte(8'h00, t);
        idle(2);
        chk("err_sat", longint'(SyncErrCnt), 255);

        // Let outstanding expectations drain, bounded
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
        chk("sb_drain", longint'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_decoder.md
Name: ps2_mouse_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes completed receive frames as one-cycle byte strobes in the system clock domain. Synchronising the receiver's Interrupt into a single-cycle strobe happens upstream of this block.
- Assembles standard 3-byte PS/2 mouse packets and decodes button state.
- Accumulates a clamped on-screen cursor position for the game logic.

Parameters:
- SCREEN_W, 640, horizontal position range is 0..SCREEN_W-1
- SCREEN_H, 480, vertical position range is 0..SCREEN_H-1
- POS_W, 10, width of PosX/PosY; must hold max(SCREEN_W, SCREEN_H)-1
- TIMEOUT_CYC, 200000, inter-byte timeout in CLK cycles (2 ms at 100 MHz); used only with the optional feature

Ports:
- CLK  input  1  system clock, all logic on posedge
- Resetn  input  1  asynchronous, active-low reset
- RxByte  input  8  received data byte, valid when RxValid=1
- RxValid  input  1  one-cycle strobe, one per received byte
- Recenter  input  1  synchronous request to move the cursor to the screen centre
- PosX  output  POS_W  cursor X position, 0 = left edge
- PosY  output  POS_W  cursor Y position, 0 = top edge
- Buttons  output  3  {Middle, Right, Left}
- PacketValid  output  1  one-cycle pulse on each position/button update
- SyncErrCnt  output  8  saturating count of rejected first bytes

Behaviour:
- Reset values:
  - PosX=SCREEN_W/2 (320), PosY=SCREEN_H/2 (240).
  - Buttons=0, PacketValid=0, SyncErrCnt=0, FSM=WAIT_B0, timeout counter=0.
  - Reset asserted mid-packet discards all partial bytes.
- FSM states: WAIT_B0, WAIT_B1, WAIT_B2, UPDATE.
- WAIT_B0, on RxValid:
  - RxByte[3]==1: latch the byte as the status byte, go to WAIT_B1.
  - RxByte[3]==0: discard the byte, increment SyncErrCnt (saturates at 255), stay in WAIT_B0.
- WAIT_B1, on RxValid: latch the X byte, go to WAIT_B2.
- WAIT_B2, on RxValid: latch the Y byte, go to UPDATE.
- UPDATE lasts exactly one cycle. At the end of that cycle:
  - PosX, PosY and Buttons are registered and PacketValid=1 for one cycle.
  - Latency: the third RxValid is sampled at edge k; new outputs and PacketValid appear at edge k+1.
  - The FSM returns to WAIT_B0.
  - An RxValid arriving while in UPDATE is processed as a WAIT_B0 byte and is not dropped.
- Status byte decode: [0]L, [1]R, [2]M, [3] always 1, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Motion arithmetic:
  - dx = signed 9-bit {Xsign, Xbyte}; dy = signed 9-bit {Ysign, Ybyte}.
  - Overflow bit set on an axis: that axis's delta is forced to 0. Buttons still update.
  - Compute in signed POS_W+2 bits: newX = PosX + dx and newY = PosY - dy (PS/2 +Y is up; screen Y grows downward).
  - Clamp each axis: result <0 gives 0; result >max gives max (SCREEN_W-1 or SCREEN_H-1). No wrap-around.
- Recenter:
  - Sets PosX/PosY to the centre on the next edge.
  - If it coincides with UPDATE, Recenter wins for position; Buttons still take the packet values and PacketValid still pulses.
  - FSM state is unaffected.
- PacketValid is never high for two consecutive cycles.

Optional Feature:
- Macro: PS2_MOUSE_TIMEOUT_EN.
- Defined:
  - A counter clears on every RxValid and increments while the FSM is in WAIT_B1 or WAIT_B2.
  - Reaching TIMEOUT_CYC forces WAIT_B0 and discards the partial packet.
  - SyncErrCnt is not incremented on timeout.
  - An RxValid in the same cycle as the timeout is treated as a WAIT_B0 byte.
- Undefined: no counter; the FSM waits indefinitely for the remaining bytes.

Decomposition:
- Package ps2_mouse_pkg:
  - FSM state enum.
  - Status-bit index constants (BTN_L=0, BTN_R=1, BTN_M=2, SYNC=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7).
  - Default screen constants.
- Sub-module mouse_axis_clamp, instantiated once per axis:
  - Inputs: current position, signed 9-bit delta, overflow flag, max value.
  - Output: clamped next position.
  - Purely combinational.

Test Plan:
- Reset: assert Resetn=0 mid-packet after bytes 0x08,0x05 -> PosX=320, PosY=240, Buttons=0, SyncErrCnt=0. The next bytes 0x08,0x01,0x01 decode as a fresh packet.
- Basic packet: bytes 0x09,0x05,0x03 -> Buttons=3'b001, PosX=325, PosY=237, PacketValid high exactly 1 cycle, 1 cycle after the third strobe.
- Negative and clamp:
  - 0x18,0xF6,0x00 -> PosX=310.
  - Recenter, then drive PosX to 5 via positive/negative packets.
  - Then 0x18,0xF6,0x00 -> PosX=0 (clamped, no wrap).
  - 0x28,0x00,0x80 (dy=-128) from PosY=400 -> PosY=479.
- Resync: stray byte 0x00 -> discarded, SyncErrCnt=1. The following 0x0A,0x00,0x00 -> Buttons=3'b010, position unchanged.
- Overflow and back-to-back:
  - 0x48,0x7F,0x02 -> PosX unchanged, PosY=238.
  - Next packet's first byte strobed in the UPDATE cycle -> accepted, second packet decodes correctly.
- Timeout (with PS2_MOUSE_TIMEOUT_EN): 0x08,0x05, idle TIMEOUT_CYC+1 cycles, then 0x08,0x01,0x01 -> PosX=321, PosY=239. Without the macro, the same stimulus yields one update using 0x05/0x08 as the deltas.
